// File: rtl/riv_rdy_vld_buffer.sv
// riv_rdy_vld_buffer
// ------------------
// Parametrised ready/valid elastic buffer holding up to DEPTH beats.
// Incoming beats are AND-masked with data_mask when they are written, so a
// later change of data_mask never affects beats that are already stored.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset (clears pointers and level)
//   flush        synchronous discard of every stored beat
//   data_mask    per-bit AND mask applied to in_data on write
//   in_valid     producer beat valid
//   in_ready     buffer can accept a beat (registered state only, gated by rst)
//   in_data      producer data
//   out_valid    head beat valid (level != 0)
//   out_ready    consumer accepts the head beat
//   out_data     data at the read pointer
//   level        number of stored beats
//   almost_full  level >= ALMOST_FULL_THRESH
module riv_rdy_vld_buffer #(
  parameter int DATA_WIDTH         = 64,
  parameter int DEPTH              = 4,
  parameter int ALMOST_FULL_THRESH = 3,
  parameter int LEVEL_WIDTH        = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [DATA_WIDTH-1:0]  data_mask,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [LEVEL_WIDTH-1:0] level,
  output logic                   almost_full
);

  localparam int PTR_W = $clog2(DEPTH);

  // Reject configurations the pointer arithmetic cannot support.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("riv_rdy_vld_buffer: DEPTH must be a power of 2 and >= 2");
  end
  if ((ALMOST_FULL_THRESH < 1) || (ALMOST_FULL_THRESH > DEPTH)) begin : g_bad_thresh
    $error("riv_rdy_vld_buffer: ALMOST_FULL_THRESH must be within 1..DEPTH");
  end
  if (DATA_WIDTH < 1) begin : g_bad_width
    $error("riv_rdy_vld_buffer: DATA_WIDTH must be >= 1");
  end

  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LEVEL_WIDTH-1:0] level_q, level_d;
  logic                   almost_full_q, almost_full_d;
  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]  masked_data;
  logic                   push;
  logic                   pop;

  genvar gi;
  for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_mask
    assign masked_data[gi] = in_data[gi] & data_mask[gi];
  end

  // Handshake outputs depend on registered level only (plus rst gating), so
  // there is no combinational path from out_ready to in_ready or from the
  // input side to the output side.
  assign in_ready    = !rst && (level_q != LEVEL_WIDTH'(DEPTH));
  assign out_valid   = (level_q != '0);
  assign out_data    = mem_q[rd_ptr_q];
  assign level       = level_q;
  assign almost_full = almost_full_q;

  // A flush overrides any simultaneous push or pop.
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    level_d       = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      level_d = level_q + LEVEL_WIDTH'(push) - LEVEL_WIDTH'(pop);
    end
    // Registered alongside level so the flag always matches the current level.
    almost_full_d = (level_d >= LEVEL_WIDTH'(ALMOST_FULL_THRESH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      almost_full_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      almost_full_q <= almost_full_d;
    end
  end

  // Storage is deliberately not reset; validity is tracked by level alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= masked_data;
    end
  end

endmodule

// File: doc/riv_rdy_vld_buffer.md
Name: riv_rdy_vld_buffer

Overview:
- Parametrised ready/valid elastic buffer. Next generation of the team's single-stage ready/valid source path, generalised in data width and buffering depth.
- Stores up to DEPTH beats and applies a per-bit data mask on ingress.
- Reports fill level and an almost-full flag, and supports a synchronous flush.
- Sits between any ready/valid producer and consumer in the link datapath. Used to decouple back-pressure and to absorb bursts.

Parameters:
- DATA_WIDTH, 64, width of in_data/out_data/data_mask (>=1).
- DEPTH, 4, number of storage entries (power of 2, >=2).
- ALMOST_FULL_THRESH, 3, level at or above which almost_full asserts (1..DEPTH).
- LEVEL_WIDTH, $clog2(DEPTH+1), width of level output (derived, not overridden).

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous discard of all stored beats.
- data_mask  input  DATA_WIDTH  AND-mask applied to in_data at write.
- in_valid  input  1  producer beat valid.
- in_ready  output  1  buffer can accept a beat.
- in_data  input  DATA_WIDTH  producer data.
- out_valid  output  1  head beat valid.
- out_ready  input  1  consumer accepts head beat.
- out_data  output  DATA_WIDTH  head beat data.
- level  output  LEVEL_WIDTH  number of stored beats.
- almost_full  output  1  level >= ALMOST_FULL_THRESH.

Behaviour:
- Reset
  - One clock, clk. Reset rst is asynchronous, active-high.
  - While rst is high: write/read pointers = 0, level = 0, out_valid = 0, almost_full = 0, in_ready = 0.
  - in_ready is combinationally gated by rst.
  - Storage array is not reset.
  - First rising clk edge after rst deasserts: in_ready = 1.
  - rst asserted mid-transfer discards all contents immediately. No beat in flight completes.
- Push and pop
  - Push: in_valid && in_ready at a rising edge writes (in_data & data_mask) at the write pointer. The write pointer increments mod DEPTH.
  - Pop: out_valid && out_ready at a rising edge advances the read pointer mod DEPTH.
  - out_data always reflects the entry at the read pointer.
- Handshake outputs
  - in_ready = !rst && (level != DEPTH). It is a function of registered state only.
  - There is no combinational path from out_ready to in_ready. When full, a pop frees a slot for a push only on the following cycle.
  - out_valid = (level != 0). It is registered state only.
  - There is no combinational path from in_valid/in_data to out_valid/out_data.
  - Minimum latency: a beat pushed at edge N is presented with out_valid = 1 in cycle N+1 (one cycle).
- Level accounting
  - Push only: level +1. Pop only: level -1. Push and pop together (0 < level < DEPTH): level unchanged, order preserved.
  - Push while empty with out_ready = 1: the beat is not popped that edge (out_valid was 0). It appears next cycle.
  - almost_full is registered consistently with level, i.e. computed from the current level.
- Stability
  - Once out_valid = 1, out_valid and out_data remain stable until popped.
  - Flush is the only exception.
  - data_mask changes never alter already-stored beats.
- Flush
  - flush = 1 at a rising edge sets both pointers = 0 and level = 0.
  - Any simultaneous push or pop is discarded or ignored.
  - out_valid = 0 and in_ready = 1 in the next cycle.
- Data rules
  - Beats are emitted in push order, with no duplication or loss.
  - out_data is don't-care while out_valid = 0. The bench must not check it then.
- Illegal configurations: DEPTH not a power of 2, or ALMOST_FULL_THRESH outside 1..DEPTH, shall fail elaboration.

Test Plan:
- Reset/idle: assert rst for 3 cycles, then release.
  - During rst: in_ready = 0, out_valid = 0, level = 0.
  - One cycle after release: in_ready = 1.
- Fill/drain (DEPTH=4, THRESH=3): push 0x11, 0x22, 0x33, 0x44 back-to-back with out_ready = 0.
  - level steps 1→4. almost_full rises after the 3rd push. in_ready = 0 at level 4.
  - Then hold out_ready = 1: out_data = 0x11, 0x22, 0x33, 0x44 on consecutive cycles, ending at level = 0.
- Full with simultaneous push/pop: at level = 4, drive in_valid = 1 and out_ready = 1.
  - Cycle 1: only the pop occurs (level = 3).
  - Cycle 2: push and pop together, level stays 3. Order is preserved across pointer wrap-around.
- Mask: data_mask = 0x00FF, push in_data = 0xABCD, then change data_mask to 0xFFFF before the pop.
  - Popped out_data = 0x00CD.
- Flush: with level = 3, assert flush together with a push.
  - Next cycle: level = 0, out_valid = 0, in_ready = 1.
  - The subsequently pushed 0x55 is the next beat out.
- Random back-pressure: 10k random beats with random in_valid/out_ready.
  - Scoreboard shows no loss, duplication or reordering.
  - out_data is stable while out_valid && !out_ready.
